async_mmap_read_streamer: RTL and testbench

ASYNC_MMAP_READ_STREAMER -- requirements
Module: async_mmap_read_streamer

---
 rtl/async_mmap_read_streamer_pkg.sv | 12 +
 rtl/async_mmap_read_streamer.sv | 152 +++++++++++++++
 tb/tb_async_mmap_read_streamer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/async_mmap_read_streamer_pkg.sv
// Default sizing shared by the read streamer and the blocks that instantiate it.
// The module-local parameters below take these values unless a caller overrides them.
package async_mmap_read_streamer_pkg;

  localparam int unsigned DefAddrWidth        = 64;
  localparam int unsigned DefDataWidth        = 512;
  localparam int unsigned DefDataWidthBytesLog = 6;
  localparam int unsigned DefLenWidth         = 32;
  localparam int unsigned DefMaxOutstanding   = 64;
  localparam int unsigned DefOutstandingWidth = 7;

endpackage : async_mmap_read_streamer_pkg

// File: rtl/async_mmap_read_streamer.sv
// async_mmap_read_streamer
// Turns one {len, base} request into len consecutive beat reads on an async_mmap
// read port and streams the returned beats, tagged with a last flag, into a FIFO.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_din/write/full_n request push interface ({len, base byte address})
//   read_addr_*          per-beat address push to async_mmap
//   read_data_*          beat pop from async_mmap
//   out_din/write/full_n {last, data} push to the consumer FIFO
//   busy                 a request is in progress
module async_mmap_read_streamer
  import async_mmap_read_streamer_pkg::*;
#(
  parameter int unsigned AddrWidth         = DefAddrWidth,
  parameter int unsigned DataWidth         = DefDataWidth,
  parameter int unsigned DataWidthBytesLog = DefDataWidthBytesLog,
  parameter int unsigned LenWidth          = DefLenWidth,
  parameter int unsigned MaxOutstanding    = DefMaxOutstanding,
  parameter int unsigned OutstandingWidth  = DefOutstandingWidth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LenWidth+AddrWidth-1:0] req_din,
  input  logic                          req_write,
  output logic                          req_full_n,
  output logic [AddrWidth-1:0]          read_addr_din,
  output logic                          read_addr_write,
  input  logic                          read_addr_full_n,
  input  logic [DataWidth-1:0]          read_data_dout,
  input  logic                          read_data_empty_n,
  output logic                          read_data_read,
  output logic [DataWidth:0]            out_din,
  output logic                          out_write,
  input  logic                          out_full_n,
  output logic                          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [AddrWidth-1:0]        base_q;
  logic [LenWidth-1:0]         len_q;
  logic [LenWidth-1:0]         issued_cnt_q;
  logic [LenWidth-1:0]         recv_cnt_q;
  logic [OutstandingWidth-1:0] outstanding_q;

  logic [LenWidth-1:0]  req_len;
  logic [AddrWidth-1:0] req_base;
  logic                 accept;
  logic                 issue;
  logic                 pop;
  logic                 last_beat;
  logic                 final_issue;

  assign req_len     = req_din[LenWidth+AddrWidth-1 -: LenWidth];
  assign req_base    = req_din[AddrWidth-1:0];
  assign last_beat   = (recv_cnt_q == len_q - LenWidth'(1));
  assign final_issue = (issued_cnt_q == len_q - LenWidth'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero-length request is accepted but never leaves IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && (req_len != '0)) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (pop && last_beat) begin
          state_d = IDLE;
        end else if (issue && final_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / handshake logic; everything is held off while rst is high so a
  // reset mid-request cannot leak one more address or beat
  always_comb begin
    req_full_n = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    issue      = 1'b0;
    pop        = 1'b0;

    busy       = (state_q != IDLE);
    req_full_n = !rst && (state_q == IDLE);
    accept     = req_write && req_full_n;
    issue      = !rst && (state_q == ISSUE) && read_addr_full_n &&
                 (outstanding_q < OutstandingWidth'(MaxOutstanding));
    pop        = !rst && (state_q != IDLE) && read_data_empty_n && out_full_n &&
                 (recv_cnt_q < issued_cnt_q);
  end

  assign read_addr_write = issue;
  assign read_addr_din   = base_q + (AddrWidth'(issued_cnt_q) << DataWidthBytesLog);
  assign read_data_read  = pop;
  assign out_write       = pop;
  assign out_din         = {last_beat, read_data_dout};

  // Request registers and beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q        <= '0;
      len_q         <= '0;
      issued_cnt_q  <= '0;
      recv_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      if (accept) begin
        base_q       <= req_base;
        len_q        <= req_len;
        issued_cnt_q <= '0;
        recv_cnt_q   <= '0;
      end else begin
        if (issue) begin
          issued_cnt_q <= issued_cnt_q + LenWidth'(1);
        end
        if (pop) begin
          recv_cnt_q <= recv_cnt_q + LenWidth'(1);
        end
      end

      // Simultaneous issue and pop cancel out
      unique case ({issue, pop})
        2'b10:   outstanding_q <= outstanding_q + OutstandingWidth'(1);
        2'b01:   outstanding_q <= outstanding_q - OutstandingWidth'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

endmodule : async_mmap_read_streamer

// File: tb/tb_async_mmap_read_streamer.sv
// Directed bench for async_mmap_read_streamer with a small async_mmap read model.
module tb_async_mmap_read_streamer;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 512;
  localparam int unsigned LW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LW+AW-1:0] req_din = '0;
  logic             req_write = 1'b0;
  logic             req_full_n;
  logic [AW-1:0]    read_addr_din;
  logic             read_addr_write;
  logic             read_addr_full_n = 1'b1;
  logic [DW-1:0]    read_data_dout;
  logic             read_data_empty_n;
  logic             read_data_read;
  logic [DW:0]      out_din;
  logic             out_write;
  logic             out_full_n = 1'b1;
  logic             busy;

  logic data_en = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  async_mmap_read_streamer #(
    .MaxOutstanding  (4),
    .OutstandingWidth(3)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_din          (req_din),
    .req_write        (req_write),
    .req_full_n       (req_full_n),
    .read_addr_din    (read_addr_din),
    .read_addr_write  (read_addr_write),
    .read_addr_full_n (read_addr_full_n),
    .read_data_dout   (read_data_dout),
    .read_data_empty_n(read_data_empty_n),
    .read_data_read   (read_data_read),
    .out_din          (out_din),
    .out_write        (out_write),
    .out_full_n       (out_full_n),
    .busy             (busy)
  );

  // async_mmap model: each pushed address returns one beat holding that address
  logic [63:0] mem [64];
  logic [5:0]  wr_ptr, rd_ptr;

  always @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (read_addr_write) begin
        mem[wr_ptr] <= read_addr_din;
        wr_ptr      <= wr_ptr + 6'd1;
      end
      if (read_data_read) begin
        rd_ptr <= rd_ptr + 6'd1;
      end
    end
  end

  assign read_data_empty_n = data_en && (wr_ptr != rd_ptr);
  assign read_data_dout    = {8{mem[rd_ptr]}};

  // Transaction logs
  logic [63:0] iss_log [256];
  int          iss_cyc [256];
  logic [63:0] out_lo  [256];
  logic        out_last[256];
  int          out_cyc [256];
  int          iss_n = 0;
  int          out_n = 0;
  int          bad_pop = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_addr_write) begin
      iss_log[iss_n] <= read_addr_din;
      iss_cyc[iss_n] <= cyc + 1;
      iss_n          <= iss_n + 1;
    end
    if (out_write) begin
      out_lo[out_n]   <= out_din[63:0];
      out_last[out_n] <= out_din[DW];
      out_cyc[out_n]  <= cyc + 1;
      out_n           <= out_n + 1;
    end
    if (read_data_read && !out_full_n) begin
      bad_pop <= bad_pop + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic [31:0] len, input logic [63:0] base);
    req_din   = {len, base};
    req_write = 1'b1;
    @(negedge clk);
    req_write = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int idle_cyc);
    ok = 1'b0;
    idle_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        ok = 1'b1;
        idle_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit          ok;
    int          idle_cyc;
    int          ib, ob;
    logic [15:0] lm;

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_full_n", 64'(req_full_n), 64'd1);
    chk("rst_addr_write", 64'(read_addr_write), 64'd0);
    chk("rst_out_write", 64'(out_write), 64'd0);

    // Basic read: 4 beats from 0x1000
    ib = iss_n; ob = out_n;
    do_req(32'd4, 64'h1000);
    chk("basic_first_issue", 64'(read_addr_write), 64'd1);
    chk("basic_first_addr", read_addr_din, 64'h1000);
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_full_n", 64'(req_full_n), 64'd0);
    wait_idle(50, ok, idle_cyc);
    chk("basic_done", 64'(ok), 64'd1);
    chk("basic_n_issue", 64'(iss_n - ib), 64'd4);
    chk("basic_n_out", 64'(out_n - ob), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_addr", iss_log[ib + i], 64'h1000 + 64'(i * 64));
      chk("basic_data", out_lo[ob + i], 64'h1000 + 64'(i * 64));
    end
    for (int i = 1; i < 4; i++) begin
      chk("basic_issue_gap", 64'(iss_cyc[ib + i] - iss_cyc[ib + i - 1]), 64'd1);
    end
    lm = '0;
    for (int i = 0; i < 4; i++) lm[i] = out_last[ob + i];
    chk("basic_last_mask", 64'(lm), 64'h8);
    chk("basic_busy_fall", 64'(idle_cyc), 64'(out_cyc[ob + 3]));

    // Zero length
    ib = iss_n; ob = out_n;
    do_req(32'd0, 64'h2000);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_full_n", 64'(req_full_n), 64'd1);
    chk("zero_addr_write", 64'(read_addr_write), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_n_issue", 64'(iss_n - ib), 64'd0);
    chk("zero_n_out", 64'(out_n - ob), 64'd0);

    // Outstanding cap of 4 with data withheld
    ib = iss_n; ob = out_n;
    data_en = 1'b0;
    do_req(32'd10, 64'h4000);
    repeat (20) @(negedge clk);
    chk("cap_n_issue", 64'(iss_n - ib), 64'd4);
    chk("cap_stalled", 64'(read_addr_write), 64'd0);
    chk("cap_n_out_held", 64'(out_n - ob), 64'd0);
    data_en = 1'b1;
    wait_idle(100, ok, idle_cyc);
    chk("cap_done", 64'(ok), 64'd1);
    chk("cap_n_issue_all", 64'(iss_n - ib), 64'd10);
    chk("cap_n_out", 64'(out_n - ob), 64'd10);
    for (int i = 0; i < 10; i++) begin
      chk("cap_data", out_lo[ob + i], 64'h4000 + 64'(i * 64));
    end
    lm = '0;
    for (int i = 0; i < 10; i++) lm[i] = out_last[ob + i];
    chk("cap_last_mask", 64'(lm), 64'h200);

    // Output backpressure toggling every cycle
    ib = iss_n; ob = out_n;
    do_req(32'd8, 64'h8000);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      out_full_n = ~out_full_n;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    out_full_n = 1'b1;
    chk("bp_done", 64'(ok), 64'd1);
    chk("bp_n_out", 64'(out_n - ob), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("bp_data", out_lo[ob + i], 64'h8000 + 64'(i * 64));
    end
    lm = '0;
    for (int i = 0; i < 8; i++) lm[i] = out_last[ob + i];
    chk("bp_last_mask", 64'(lm), 64'h80);
    chk("bp_pop_while_full", 64'(bad_pop), 64'd0);

    // Address wrap
    ib = iss_n; ob = out_n;
    do_req(32'd2, 64'hFFFF_FFFF_FFFF_FFC0);
    wait_idle(50, ok, idle_cyc);
    chk("wrap_done", 64'(ok), 64'd1);
    chk("wrap_n_issue", 64'(iss_n - ib), 64'd2);
    chk("wrap_addr0", iss_log[ib], 64'hFFFF_FFFF_FFFF_FFC0);
    chk("wrap_addr1", iss_log[ib + 1], 64'h0);
    chk("wrap_n_out", 64'(out_n - ob), 64'd2);

    // Reset after 3 of 8 beats, then a fresh request
    ob = out_n;
    do_req(32'd8, 64'hA000);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_n - ob == 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rstmid_reached3", 64'(ok), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_out_write", 64'(out_write), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_full_n", 64'(req_full_n), 64'd1);
    chk("rstmid_out_write2", 64'(out_write), 64'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_n_out", 64'(out_n - ob), 64'd3);
    ib = iss_n; ob = out_n;
    do_req(32'd2, 64'hB000);
    wait_idle(50, ok, idle_cyc);
    chk("post_done", 64'(ok), 64'd1);
    chk("post_n_out", 64'(out_n - ob), 64'd2);
    chk("post_data0", out_lo[ob], 64'hB000);
    chk("post_data1", out_lo[ob + 1], 64'hB040);
    lm = '0;
    for (int i = 0; i < 2; i++) lm[i] = out_last[ob + i];
    chk("post_last_mask", 64'(lm), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_async_mmap_read_streamer
